// File: rtl/video_timing_gen_pkg.sv
// Shared timing defaults and pattern-select encoding for the raster generator.
package video_pkg;

  localparam int unsigned DEF_COLORDEPTH = 8;
  localparam int unsigned DEF_H_ACTIVE   = 1600;
  localparam int unsigned DEF_H_FP       = 24;
  localparam int unsigned DEF_H_SYNC     = 80;
  localparam int unsigned DEF_H_BP       = 96;
  localparam int unsigned DEF_V_ACTIVE   = 900;
  localparam int unsigned DEF_V_FP       = 1;
  localparam int unsigned DEF_V_SYNC     = 3;
  localparam int unsigned DEF_V_BP       = 96;

  typedef enum logic [1:0] {
    PAT_HRAMP   = 2'd0,
    PAT_VRAMP   = 2'd1,
    PAT_CHECKER = 2'd2,
    PAT_FLAT    = 2'd3
  } pat_e;

endpackage

// File: rtl/video_timing_gen_counter.sv
// Wrap counter with clock-enable; o_wrap pulses on the enabled cycle that returns to 0.
module vtg_counter #(
  parameter int unsigned MAX = 1800,
  parameter int unsigned W   = $clog2(MAX)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_ce,
  output logic [W-1:0] o_cnt,
  output logic         o_wrap
);

  logic [W-1:0] r_cnt;
  logic         w_last;

  assign w_last = (r_cnt == W'(MAX - 1));
  assign o_wrap = i_ce & w_last;
  assign o_cnt  = r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_ce) begin
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator with registered stream outputs.
// VTG_PATTERN_EN builds the test-pattern source; otherwise data_i is passed through.
module video_timing_gen
  import video_pkg::*;
#(
  parameter int unsigned COLORDEPTH = DEF_COLORDEPTH,
  parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
  parameter int unsigned H_FP       = DEF_H_FP,
  parameter int unsigned H_SYNC     = DEF_H_SYNC,
  parameter int unsigned H_BP       = DEF_H_BP,
  parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
  parameter int unsigned V_FP       = DEF_V_FP,
  parameter int unsigned V_SYNC     = DEF_V_SYNC,
  parameter int unsigned V_BP       = DEF_V_BP,
  parameter logic        HS_POL     = 1'b1,
  parameter logic        VS_POL     = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic [1:0]            pat_sel,
  input  logic [COLORDEPTH-1:0] data_i,
  output logic [COLORDEPTH-1:0] data_o,
  output logic                  dv_o,
  output logic                  hs_o,
  output logic                  vs_o,
  output logic                  line_end_o,
  output logic                  frame_start_o
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);

  logic [HW-1:0]         w_h;
  logic [VW-1:0]         w_v;
  logic                  w_h_wrap;
  logic                  w_v_wrap;
  logic                  w_dv;
  logic                  w_hs_act;
  logic                  w_vs_act;
  logic [COLORDEPTH-1:0] w_pix;

  logic                  r_origin;
  logic [COLORDEPTH-1:0] r_data;
  logic                  r_dv;
  logic                  r_hs;
  logic                  r_vs;
  logic                  r_le;
  logic                  r_fs;

  vtg_counter #(.MAX(H_TOTAL), .W(HW)) u_h_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_ce   (ce),
    .o_cnt  (w_h),
    .o_wrap (w_h_wrap)
  );

  vtg_counter #(.MAX(V_TOTAL), .W(VW)) u_v_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_ce   (w_h_wrap),
    .o_cnt  (w_v),
    .o_wrap (w_v_wrap)
  );

  always_comb begin
    w_dv     = (w_h < HW'(H_ACTIVE)) && (w_v < VW'(V_ACTIVE));
    w_hs_act = (w_h >= HW'(H_ACTIVE + H_FP)) && (w_h < HW'(H_ACTIVE + H_FP + H_SYNC));
    w_vs_act = (w_v >= VW'(V_ACTIVE + V_FP)) && (w_v < VW'(V_ACTIVE + V_FP + V_SYNC));
  end

`ifdef VTG_PATTERN_EN
  pat_e r_pat_q;
  pat_e w_pat;
  logic w_unused_data;

  assign w_unused_data = ^data_i;

  // The frame's first pixel already uses the newly sampled select, so a whole frame shares one pattern.
  assign w_pat = r_origin ? pat_e'(pat_sel) : r_pat_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pat_q <= PAT_HRAMP;
    end else if (ce && r_origin) begin
      r_pat_q <= pat_e'(pat_sel);
    end
  end

  always_comb begin
    w_pix = '0;
    case (w_pat)
      PAT_HRAMP:   w_pix = COLORDEPTH'(w_h);
      PAT_VRAMP:   w_pix = COLORDEPTH'(w_v);
      PAT_CHECKER: w_pix = (((32'(w_h) ^ 32'(w_v)) & 32'h20) != 32'd0) ? '1 : '0;
      PAT_FLAT:    w_pix = {1'b1, {(COLORDEPTH-1){1'b0}}};
      default:     w_pix = '0;
    endcase
  end
`else
  logic w_unused_pat;

  assign w_unused_pat = ^pat_sel;
  assign w_pix        = data_i;
`endif

  // (0,0) is only reachable from reset or a frame wrap, so a flag replaces a two-counter compare.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_origin <= 1'b1;
      r_data   <= '0;
      r_dv     <= 1'b0;
      r_hs     <= ~HS_POL;
      r_vs     <= ~VS_POL;
      r_le     <= 1'b0;
      r_fs     <= 1'b0;
    end else if (ce) begin
      r_origin <= w_v_wrap;
      r_data   <= w_dv ? w_pix : '0;
      r_dv     <= w_dv;
      r_hs     <= w_hs_act ? HS_POL : ~HS_POL;
      r_vs     <= w_vs_act ? VS_POL : ~VS_POL;
      r_le     <= w_dv && (w_h == HW'(H_ACTIVE - 1));
      r_fs     <= r_origin;
    end
  end

  assign data_o        = r_data;
  assign dv_o          = r_dv;
  assign hs_o          = r_hs;
  assign vs_o          = r_vs;
  assign line_end_o    = r_le;
  assign frame_start_o = r_fs;

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench for video_timing_gen on a reduced 48x40 raster.
module tb_video_timing_gen;

  localparam int unsigned HA  = 40;
  localparam int unsigned HF  = 2;
  localparam int unsigned HSW = 4;
  localparam int unsigned HB  = 2;
  localparam int unsigned VA  = 36;
  localparam int unsigned VF  = 1;
  localparam int unsigned VSW = 2;
  localparam int unsigned VB  = 1;
  localparam int unsigned HT  = HA + HF + HSW + HB;
  localparam int unsigned VT  = VA + VF + VSW + VB;
  localparam int unsigned TOT = HT * VT;
  localparam logic        HSP = 1'b1;
  localparam logic        VSP = 1'b0;

  typedef struct packed {
    logic [7:0] d;
    logic       dv;
    logic       hs;
    logic       vs;
    logic       le;
    logic       fs;
  } out_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ce = 1'b0;
  logic [1:0] pat_sel = 2'd2;
  logic [7:0] data_i;
  logic [7:0] data_o;
  logic       dv_o, hs_o, vs_o, line_end_o, frame_start_o;

  int unsigned checks = 0;
  int unsigned errors = 0;

  video_timing_gen #(
    .COLORDEPTH(8),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .HS_POL(HSP), .VS_POL(VSP)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ce            (ce),
    .pat_sel       (pat_sel),
    .data_i        (data_i),
    .data_o        (data_o),
    .dv_o          (dv_o),
    .hs_o          (hs_o),
    .vs_o          (vs_o),
    .line_end_o    (line_end_o),
    .frame_start_o (frame_start_o)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] src_pix(int unsigned p);
    return 8'(((p % HT) + 3 * (p / HT)) & 255);
  endfunction

  function automatic out_t reset_out();
    out_t o;
    o = '0;
    o.hs = ~HSP;
    o.vs = ~VSP;
    return o;
  endfunction

  // Expected registered outputs describing raster position p.
  function automatic out_t model_out(int unsigned p, logic [1:0] pat, logic [7:0] din);
    out_t        o;
    int unsigned h;
    int unsigned v;
    h    = p % HT;
    v    = p / HT;
    o.dv = (h < HA) && (v < VA);
    o.hs = (h >= HA + HF && h < HA + HF + HSW) ? HSP : ~HSP;
    o.vs = (v >= VA + VF && v < VA + VF + VSW) ? VSP : ~VSP;
    o.le = o.dv && (h == HA - 1);
    o.fs = (p == 0);
`ifdef VTG_PATTERN_EN
    case (pat)
      2'd0: o.d = 8'(h % 256);
      2'd1: o.d = 8'(v % 256);
      2'd2: o.d = (((h / 32) % 2) != ((v / 32) % 2)) ? 8'hFF : 8'h00;
      default: o.d = 8'h80;
    endcase
`else
    o.d = (pat == 2'd0) ? din : din;
`endif
    if (!o.dv) o.d = 8'h00;
    return o;
  endfunction

  int unsigned m_p;
  logic [1:0]  m_pat;
  out_t        m_exp;
  out_t        w_dut;

  assign data_i = src_pix(m_p);
  assign w_dut  = {data_o, dv_o, hs_o, vs_o, line_end_o, frame_start_o};

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_p   <= 0;
      m_pat <= 2'd0;
      m_exp <= reset_out();
    end else if (ce) begin
      if (m_p == 0) m_pat <= pat_sel;
      m_exp <= model_out(m_p, (m_p == 0) ? pat_sel : m_pat, data_i);
      m_p   <= (m_p == TOT - 1) ? 0 : m_p + 1;
    end
  end

  task automatic step();
    @(negedge clk);
    checks++;
    if (w_dut !== m_exp) begin
      errors++;
      $display("FAIL cycle t=%0t got d=%h dv=%b hs=%b vs=%b le=%b fs=%b want d=%h dv=%b hs=%b vs=%b le=%b fs=%b",
               $time, w_dut.d, w_dut.dv, w_dut.hs, w_dut.vs, w_dut.le, w_dut.fs,
               m_exp.d, m_exp.dv, m_exp.hs, m_exp.vs, m_exp.le, m_exp.fs);
    end
  endtask

  task automatic lcheck(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  initial begin
    int dv_run, dv_low, le_cnt, le_first, hs_first, hs_line0, vs_first, vs_cnt, dv_tail, fs_cnt;
    int unsigned budget;
    bit in_run, in_low;

    rst = 1'b0;
    ce  = 1'b0;
    pat_sel = 2'd2;
    repeat (3) step();
    lcheck("rst_dv", int'(dv_o), 0);
    lcheck("rst_hs", int'(hs_o), 0);
    lcheck("rst_vs", int'(vs_o), 1);
    lcheck("rst_fs", int'(frame_start_o), 0);

    rst = 1'b1;
    ce  = 1'b1;
    step();
    lcheck("fs_first", int'(frame_start_o), 1);
    lcheck("dv_first", int'(dv_o), 1);

    dv_run = 0; dv_low = 0; le_cnt = 0; le_first = -1; hs_first = -1; hs_line0 = 0;
    vs_first = -1; vs_cnt = 0; dv_tail = 0; fs_cnt = 0; in_run = 1'b1; in_low = 1'b0;
    for (int i = 0; i < int'(TOT); i++) begin
      if (in_run) begin
        if (dv_o) dv_run++;
        else begin in_run = 1'b0; in_low = 1'b1; end
      end
      if (in_low) begin
        if (!dv_o) dv_low++;
        else in_low = 1'b0;
      end
      if (line_end_o) begin
        le_cnt++;
        if (le_first < 0) le_first = i;
      end
      if (hs_o == HSP) begin
        if (hs_first < 0) hs_first = i;
        if (i < int'(HT)) hs_line0++;
      end
      if (vs_o == VSP) begin
        if (vs_first < 0) vs_first = i;
        vs_cnt++;
      end
      if (i >= int'(VA * HT) && dv_o) dv_tail++;
      if (frame_start_o) fs_cnt++;
`ifdef VTG_PATTERN_EN
      if (i == 0)    lcheck("pix_0_0", int'(data_o), 0);
      if (i == 32)   lcheck("pix_32_0", int'(data_o), 255);
      if (i == 1568) lcheck("pix_32_32", int'(data_o), 0);
      if (i == 600)  lcheck("pix_midframe_hold", int'(data_o), 0);
      if (i == 500)  pat_sel = 2'd3;
`else
      if (i == 32)   lcheck("pix_32_0", int'(data_o), 32);
      if (i == 40)   lcheck("pix_blank", int'(data_o), 0);
      if (i == 1568) lcheck("pix_32_32", int'(data_o), 128);
`endif
      step();
    end
    lcheck("fs_period", int'(frame_start_o), 1);
    lcheck("fs_once", fs_cnt, 1);
    lcheck("dv_run", dv_run, 40);
    lcheck("dv_low", dv_low, 8);
    lcheck("le_count", le_cnt, 36);
    lcheck("le_first", le_first, 39);
    lcheck("hs_first", hs_first, 42);
    lcheck("hs_width", hs_line0, 4);
    lcheck("vs_first", vs_first, 1776);
    lcheck("vs_width", vs_cnt, 96);
    lcheck("dv_vblank", dv_tail, 0);
`ifdef VTG_PATTERN_EN
    lcheck("pat_new_frame", int'(data_o), 128);
`else
    lcheck("pix_0_0", int'(data_o), 0);
`endif

    for (int i = 0; i < 700; i++) begin
      ce = 1'($urandom_range(1, 0));
      step();
    end
    ce = 1'b1;

    budget = 0;
    while (m_p != 10 * HT + 20 && budget < 3 * TOT) begin
      step();
      budget++;
    end
    lcheck("rst_point_reached", int'(m_p == 10 * HT + 20), 1);
    lcheck("pre_rst_dv", int'(dv_o), 1);
    #1 rst = 1'b0;
    #1;
    lcheck("async_dv", int'(dv_o), 0);
    lcheck("async_hs", int'(hs_o), 0);
    lcheck("async_vs", int'(vs_o), 1);
    lcheck("async_data", int'(data_o), 0);
    lcheck("async_le", int'(line_end_o), 0);
    lcheck("async_fs", int'(frame_start_o), 0);
    repeat (2) step();
    rst = 1'b1;
    step();
    lcheck("fs_after_rst", int'(frame_start_o), 1);
    repeat (100) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
